// File: rtl/gpio_scan_pkg.sv
// Shared types and layout helpers for the GPIO scan-chain SRAM test sequencer.
package gpio_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    CAPTURE,
    LOAD
  } seq_state_e;

  localparam int MAX_READ_LAT = 3;

  // One port descriptor: addr, din, csb, web, wmask.
  function automatic int port_w(input int addr_w, input int data_w, input int wmask_w);
    return addr_w + data_w + 2 + wmask_w;
  endfunction

  function automatic int scan_w(input int sel_w, input int addr_w, input int data_w,
                                input int wmask_w);
    return sel_w + 2 * port_w(addr_w, data_w, wmask_w);
  endfunction

endpackage

// File: rtl/gpio_scan_chain.sv
// Command/result shift register: serial shift while idle, parallel reload of both din fields.
module gpio_scan_chain #(
  parameter int SCAN_W   = 112,
  parameter int DATA_W   = 32,
  parameter int DIN0_LSB = 60,
  parameter int DIN1_LSB = 6
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              shift_en_i,
  input  logic              scan_in_i,
  input  logic              load_en_i,
  input  logic [DATA_W-1:0] load0_i,
  input  logic [DATA_W-1:0] load1_i,
  output logic [SCAN_W-1:0] chain_o
);

  logic [SCAN_W-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (shift_en_i) begin
      chain_d = {chain_q[SCAN_W-2:0], scan_in_i};
    end else if (load_en_i) begin
      chain_d[DIN0_LSB +: DATA_W] = load0_i;
      chain_d[DIN1_LSB +: DATA_W] = load1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) chain_q <= '0;
    else         chain_q <= chain_d;
  end

  assign chain_o = chain_q;

endmodule

// File: rtl/gpio_scan_sram_seq.sv
// Scan-loaded dual-port SRAM test sequencer: access FSM, burst addressing, XOR read signatures.
module gpio_scan_sram_seq
  import gpio_scan_pkg::*;
#(
  parameter int SEL_W    = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int WMASK_W  = 4,
  parameter int READ_LAT = 1,
  parameter int BURST_W  = 8
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               scan_en,
  input  logic               scan_in,
  output logic               scan_out,
  input  logic               sram_load,
  input  logic               global_csb,
  input  logic               auto_load,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic [SEL_W-1:0]   sram_sel,
  output logic               csb0,
  output logic               csb1,
  output logic               web0,
  output logic               web1,
  output logic [WMASK_W-1:0] wmask0,
  output logic [WMASK_W-1:0] wmask1,
  output logic [ADDR_W-1:0]  addr0,
  output logic [ADDR_W-1:0]  addr1,
  output logic [DATA_W-1:0]  din0,
  output logic [DATA_W-1:0]  din1,
  input  logic [DATA_W-1:0]  dout0,
  input  logic [DATA_W-1:0]  dout1
);

  localparam int PORT_W   = port_w(ADDR_W, DATA_W, WMASK_W);
  localparam int SCAN_W   = scan_w(SEL_W, ADDR_W, DATA_W, WMASK_W);
  // Offsets inside one port descriptor, counted from its LSB.
  localparam int WEB_OFS  = WMASK_W;
  localparam int CSB_OFS  = WMASK_W + 1;
  localparam int DIN_OFS  = WMASK_W + 2;
  localparam int ADDR_OFS = WMASK_W + 2 + DATA_W;
  localparam int P0_LSB   = PORT_W;
  localparam int SEL_LSB  = 2 * PORT_W;

  seq_state_e         state_q, state_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [1:0]         lat_q, lat_d;
  logic [ADDR_W-1:0]  ofs_q, ofs_d;
  logic [DATA_W-1:0]  sig0_q, sig0_d, sig1_q, sig1_d;
  logic               armed_q, armed_d;
  logic               done_q, done_d;

  logic [SCAN_W-1:0]  chain;
  logic               csb0_f, csb1_f, web0_f, web1_f;
  logic [ADDR_W-1:0]  addr0_f, addr1_f;
  logic               rd0, rd1;

  gpio_scan_chain #(
    .SCAN_W  (SCAN_W),
    .DATA_W  (DATA_W),
    .DIN0_LSB(P0_LSB + DIN_OFS),
    .DIN1_LSB(DIN_OFS)
  ) u_chain (
    .clk       (clk),
    .resetb    (resetb),
    .shift_en_i(state_q == IDLE && scan_en),
    .scan_in_i (scan_in),
    .load_en_i (state_q == LOAD || (state_q == IDLE && sram_load)),
    .load0_i   (sig0_q),
    .load1_i   (sig1_q),
    .chain_o   (chain)
  );

  assign sram_sel = chain[SEL_LSB +: SEL_W];
  assign addr0_f  = chain[P0_LSB + ADDR_OFS +: ADDR_W];
  assign din0     = chain[P0_LSB + DIN_OFS +: DATA_W];
  assign csb0_f   = chain[P0_LSB + CSB_OFS];
  assign web0_f   = chain[P0_LSB + WEB_OFS];
  assign wmask0   = chain[P0_LSB +: WMASK_W];
  assign addr1_f  = chain[ADDR_OFS +: ADDR_W];
  assign din1     = chain[DIN_OFS +: DATA_W];
  assign csb1_f   = chain[CSB_OFS];
  assign web1_f   = chain[WEB_OFS];
  assign wmask1   = chain[0 +: WMASK_W];

  assign rd0 = !csb0_f && web0_f;
  assign rd1 = !csb1_f && web1_f;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    ofs_d   = ofs_q;
    sig0_d  = sig0_q;
    sig1_d  = sig1_q;
    armed_d = armed_q;
    if (state_q == IDLE && global_csb) armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        // A strobe held low across an op must be released before it counts again.
        if (!global_csb && !scan_en && armed_q) begin
          state_d = ACCESS;
          beat_d  = burst_len;
          ofs_d   = '0;
          sig0_d  = '0;
          sig1_d  = '0;
          armed_d = 1'b0;
        end
      end
      ACCESS: begin
        if (READ_LAT > 1) begin
          state_d = WAIT;
          lat_d   = 2'(READ_LAT - 2);
        end else begin
          state_d = CAPTURE;
        end
      end
      WAIT: begin
        if (lat_q == 2'd0) state_d = CAPTURE;
        else               lat_d   = lat_q - 2'd1;
      end
      CAPTURE: begin
        if (rd0) sig0_d = sig0_q ^ dout0;
        if (rd1) sig1_d = sig1_q ^ dout1;
        if (beat_q != '0) begin
          beat_d  = beat_q - BURST_W'(1);
          ofs_d   = ofs_q + ADDR_W'(1);
          state_d = ACCESS;
        end else if (auto_load) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == IDLE) && (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      ofs_q   <= '0;
      sig0_q  <= '0;
      sig1_q  <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      ofs_q   <= ofs_d;
      sig0_q  <= sig0_d;
      sig1_q  <= sig1_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  // Burst offset only moves the address of a port that is actually accessing.
  assign addr0    = addr0_f + (csb0_f ? {ADDR_W{1'b0}} : ofs_q);
  assign addr1    = addr1_f + (csb1_f ? {ADDR_W{1'b0}} : ofs_q);
  assign csb0     = (state_q == ACCESS) ? csb0_f : 1'b1;
  assign csb1     = (state_q == ACCESS) ? csb1_f : 1'b1;
  assign web0     = (state_q == ACCESS) ? web0_f : 1'b1;
  assign web1     = (state_q == ACCESS) ? web1_f : 1'b1;
  assign scan_out = chain[SCAN_W-1];
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule
